ps2_mouse_rx: RTL and testbench
===============================

Name: ps2_mouse_rx

Overview:
- Upstream stage of the Kempston mouse port. Receives raw PS/2 mouse clock/data lines and deserialises 11-bit device-to-host frames.
- Assembles standard 3-byte movement packets and publishes them as a 25-bit packet word with a toggle strobe in bit 24, the format the Kempston block consumes.
- Receive-only. Host-to-device init commands are handled elsewhere.

Parameters:
- FILTER_LEN, 8: consecutive equal synchronised samples required before the filtered ps2_clk/ps2_data level changes.
- BIT_TIMEOUT, 6400: clk_sys cycles without a filtered clock falling edge before a partial frame is abandoned (100 us at 64 MHz).
- PKT_TIMEOUT, 128000: clk_sys cycles without a new byte before a partial packet is abandoned (2 ms at 64 MHz).

Ports:
- clk_sys, input, 1: system clock.
- reset_n, input, 1: asynchronous active-low reset.
- ps2_clk, input, 1: raw PS/2 clock pin (asynchronous).
- ps2_data, input, 1: raw PS/2 data pin (asynchronous).
- ps2_mouse, output, 25: packet word. [7:0]=byte0 (status/buttons), [15:8]=dx, [23:16]=dy, [24]=toggles once per packet.
- frame_err, output, 1: one-cycle pulse on a parity or stop-bit error.

Behaviour:
- Reset: reset_n low asynchronously clears all state. ps2_mouse=0, frame_err=0, byte FSM in IDLE, packet index=0, filters set to 1 (idle bus).
- Input conditioning: 2-FF synchroniser on each pin, then a FILTER_LEN saturating agreement filter. The sample event is a 1→0 transition of the filtered clock. Data is sampled from the filtered data in the same cycle.
- Byte FSM states:
  - IDLE: on a sample event with data=0 → DATA, bit count=0. With data=1 the event is ignored and the FSM stays in IDLE.
  - DATA: shift data in LSB first. After the 8th bit → PARITY.
  - PARITY: capture the parity bit → STOP.
  - STOP: if data=1 and the 8 data bits plus parity have odd parity, pulse byte_valid for one cycle with the byte. Otherwise pulse frame_err. Always → IDLE.
- Bit timeout: in any non-IDLE state, BIT_TIMEOUT cycles without a sample event → IDLE. The frame is discarded with no frame_err.
- Packet assembler (index 0..2):
  - idx0: accept the byte only if bit3=1 and the byte is not 0xFA or 0xAA. Otherwise discard and stay at idx0 (resync).
  - idx1, idx2: accept unconditionally.
  - Completion: one cycle after byte_valid of byte 2, ps2_mouse[23:0] updates atomically and ps2_mouse[24] inverts in that same cycle. Index returns to 0.
- Bytes are passed through raw: sign bits 4/5 and overflow bits 6/7 are not altered.
- frame_err in mid-packet forces index to 0. Bytes already collected are dropped and ps2_mouse is unchanged.
- Packet timeout: index≠0 and PKT_TIMEOUT cycles without byte_valid → index=0.
- Simultaneous events: a byte_valid and a timeout expiry in the same cycle — byte_valid wins and the timer reloads.
- Counters saturate; nothing wraps.
- Toggle semantics: the consumer detects a packet by bit24 change, so back-to-back packets must each produce exactly one toggle.

Optional Feature:
- Macro PS2_WHEEL_EN.
- Defined: packets are 4 bytes (IntelliMouse). Adds output ps2_wheel [7:0] (signed Z byte). ps2_wheel updates in the same cycle as ps2_mouse, and the toggle fires after byte 3.
- Undefined: 3-byte packets and no ps2_wheel port.

Decomposition:
- Shared package ps2_pkg: frame bit count (11), ACK byte 0xFA, BAT byte 0xAA, packet-length constants (3/4), byte-FSM state encodings.
- Sub-module ps2_byte_rx: synchroniser, filter, byte FSM and bit timeout. Outputs byte[7:0], byte_valid, frame_err.
- The top level holds the packet assembler and packet timeout.

Test Plan:
- Frames 0x09, 0x05, 0xFB (valid parity) → ps2_mouse[23:0]=0xFB0509, bit24 0→1 exactly once, frame_err never asserted.
- Frame 0x09 with bad parity, then a valid 0x08,0x01,0x02 → one frame_err pulse, then ps2_mouse[23:0]=0x020108 with one toggle.
- Leading byte 0x00 (bit3=0), then 0x08,0x10,0x20 → 0x00 discarded, ps2_mouse[23:0]=0x201008.
- 0xFA, then 0x09,0x7F,0x80 → ACK ignored, ps2_mouse[23:0]=0x807F09.
- 0x08,0x01, idle > PKT_TIMEOUT, then 0x08,0x03,0x04 → ps2_mouse[23:0]=0x040308 with a single toggle.
- 1-cycle glitches on ps2_clk shorter than FILTER_LEN during a frame → no effect. reset_n pulsed mid-frame → ps2_mouse=0, and the next full packet decodes correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared constants and types for the PS/2 mouse receive path:
//   - PS/2 frame geometry (start + 8 data + parity + stop)
//   - special device bytes that must never start a movement packet
//   - movement packet lengths (standard / IntelliMouse wheel)
//   - byte-receiver FSM state encoding
// -----------------------------------------------------------------------------
package ps2_pkg;

  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = FRAME_BITS - 3;

  localparam logic [7:0] BYTE_ACK = 8'hFA;
  localparam logic [7:0] BYTE_BAT = 8'hAA;

  localparam int PKT_LEN_STD   = 3;
  localparam int PKT_LEN_WHEEL = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } byte_state_t;

  // A packet can only start on a byte with the always-one bit 3 set, and never
  // on an ACK or BAT (both happen to have bit 3 set as well).
  function automatic logic is_lead_byte(input logic [7:0] b);
    return b[3] && (b != BYTE_ACK) && (b != BYTE_BAT);
  endfunction

endpackage

// File: rtl/ps2_byte_rx.sv
// -----------------------------------------------------------------------------
// ps2_byte_rx
// Conditions the raw PS/2 clock/data pins (2-FF synchroniser + agreement
// filter) and deserialises 11-bit device-to-host frames.
//
// Ports:
//   clk_sys      in   system clock
//   reset_n      in   asynchronous active-low reset
//   i_ps2_clk    in   raw PS/2 clock pin (asynchronous)
//   i_ps2_data   in   raw PS/2 data pin (asynchronous)
//   o_byte       out  received byte, valid while o_byte_valid is high
//   o_byte_valid out  one-cycle pulse: good parity and stop bit
//   o_frame_err  out  one-cycle pulse: bad parity or stop bit
// -----------------------------------------------------------------------------
module ps2_byte_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int BIT_TIMEOUT = 6400
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int BTW = (BIT_TIMEOUT > 1) ? $clog2(BIT_TIMEOUT) : 1;
  localparam logic [FCW-1:0] FCNT_LAST   = FCW'(FILTER_LEN - 1);
  localparam logic [BTW-1:0] BT_LAST     = BTW'(BIT_TIMEOUT - 1);
  localparam logic [2:0]     BITCNT_LAST = 3'(DATA_BITS - 1);

  // Channel 0 = clock, channel 1 = data.
  logic [1:0]          r_meta;
  logic [1:0]          r_sync;
  logic [1:0]          r_filt;
  logic [1:0][FCW-1:0] r_fcnt;
  logic                r_clk_prev;

  byte_state_t r_state;
  byte_state_t w_state_nxt;
  logic [7:0]     r_shift;
  logic [2:0]     r_bit_cnt;
  logic           r_parity;
  logic [BTW-1:0] r_bit_timer;

  logic w_fall;
  logic w_data;
  logic w_bit_to;
  logic w_stop_ok;
  logic w_byte_valid;
  logic w_frame_err;

  // Filters reset to 1 so an idle bus does not look like a falling edge.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, matching real flip-flops.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_meta     <= '1;
      r_sync     <= '1;
      r_filt     <= '1;
      r_fcnt     <= '0;
      r_clk_prev <= 1'b1;
    end else begin
      r_meta     <= {i_ps2_data, i_ps2_clk};
      r_sync     <= r_meta;
      r_clk_prev <= r_filt[0];
      // Level changes only after FILTER_LEN consecutive samples disagree with
      // it; any agreeing sample restarts the count.
      for (int i = 0; i < 2; i++) begin
        if (r_sync[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == FCNT_LAST) begin
          r_filt[i] <= r_sync[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_fall   = r_clk_prev & ~r_filt[0];
  assign w_data   = r_filt[1];
  assign w_bit_to = (r_state != ST_IDLE) && !w_fall && (r_bit_timer == BT_LAST);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_timer <= '0;
    end else if ((r_state == ST_IDLE) || w_fall) begin
      r_bit_timer <= '0;
    end else if (r_bit_timer != BT_LAST) begin
      r_bit_timer <= r_bit_timer + 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_byte_valid = 1'b0;
    w_frame_err  = 1'b0;
    // Odd parity over data + parity bit, and the stop bit must be 1.
    w_stop_ok    = w_data & (^{r_shift, r_parity});
    if (w_bit_to) begin
      w_state_nxt = ST_IDLE;
    end else if (w_fall) begin
      case (r_state)
        ST_IDLE:   if (!w_data) w_state_nxt = ST_DATA;
        ST_DATA:   if (r_bit_cnt == BITCNT_LAST) w_state_nxt = ST_PARITY;
        ST_PARITY: w_state_nxt = ST_STOP;
        ST_STOP: begin
          w_state_nxt = ST_IDLE;
          if (w_stop_ok) w_byte_valid = 1'b1;
          else           w_frame_err  = 1'b1;
        end
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_parity  <= 1'b0;
    end else if (w_fall && !w_bit_to) begin
      case (r_state)
        ST_IDLE: r_bit_cnt <= '0;
        ST_DATA: begin
          r_shift <= {w_data, r_shift[7:1]};
          if (r_bit_cnt != BITCNT_LAST) r_bit_cnt <= r_bit_cnt + 1'b1;
        end
        ST_PARITY: r_parity <= w_data;
        default: ;
      endcase
    end
  end

  assign o_byte       = r_shift;
  assign o_byte_valid = w_byte_valid;
  assign o_frame_err  = w_frame_err;

endmodule

// File: rtl/ps2_mouse_rx.sv
// -----------------------------------------------------------------------------
// ps2_mouse_rx
// Receives PS/2 mouse frames and assembles movement packets into the packet
// word consumed by the Kempston mouse block. Bit 24 toggles once per packet.
//
// Build option: define PS2_WHEEL_EN for 4-byte IntelliMouse packets; this adds
// the ps2_wheel output and moves the toggle to after the fourth byte.
//
// Ports:
//   clk_sys    in   system clock
//   reset_n    in   asynchronous active-low reset
//   ps2_clk    in   raw PS/2 clock pin (asynchronous)
//   ps2_data   in   raw PS/2 data pin (asynchronous)
//   ps2_mouse  out  [7:0] status, [15:8] dx, [23:16] dy, [24] packet toggle
//   ps2_wheel  out  signed Z byte (PS2_WHEEL_EN only)
//   frame_err  out  one-cycle pulse on a parity or stop-bit error
// -----------------------------------------------------------------------------
module ps2_mouse_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int BIT_TIMEOUT = 6400,
  parameter int PKT_TIMEOUT = 128000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [24:0] ps2_mouse,
`ifdef PS2_WHEEL_EN
  output logic [7:0]  ps2_wheel,
`endif
  output logic        frame_err
);

`ifdef PS2_WHEEL_EN
  localparam int PKT_LEN = PKT_LEN_WHEEL;
`else
  localparam int PKT_LEN = PKT_LEN_STD;
`endif
  localparam logic [1:0] IDX_LAST = 2'(PKT_LEN - 1);
  localparam int PTW = (PKT_TIMEOUT > 1) ? $clog2(PKT_TIMEOUT) : 1;
  localparam logic [PTW-1:0] PT_LAST = PTW'(PKT_TIMEOUT - 1);

  logic [7:0] w_byte;
  logic       w_byte_valid;
  logic       w_frame_err;
  logic       w_pkt_to;

  logic [1:0]     r_idx;
  logic [PTW-1:0] r_pkt_timer;
  logic [7:0]     r_b0;
  logic [7:0]     r_b1;
  logic [24:0]    r_mouse;
`ifdef PS2_WHEEL_EN
  logic [7:0]     r_b2;
  logic [7:0]     r_wheel;
`endif

  ps2_byte_rx #(
    .FILTER_LEN  (FILTER_LEN),
    .BIT_TIMEOUT (BIT_TIMEOUT)
  ) u_byte_rx (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .i_ps2_clk    (ps2_clk),
    .i_ps2_data   (ps2_data),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid),
    .o_frame_err  (w_frame_err)
  );

  assign w_pkt_to = (r_idx != 2'd0) && (r_pkt_timer == PT_LAST);

  // byte_valid is tested first, so it wins over a same-cycle timeout.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_idx       <= '0;
      r_pkt_timer <= '0;
      // NOTE: the byte holding registers are reset too; they are only a few
      // flops and this keeps X out of ps2_mouse under any packet sequence.
      r_b0        <= '0;
      r_b1        <= '0;
      r_mouse     <= '0;
`ifdef PS2_WHEEL_EN
      r_b2        <= '0;
      r_wheel     <= '0;
`endif
    end else if (w_byte_valid) begin
      r_pkt_timer <= '0;
      if (r_idx == 2'd0) begin
        if (is_lead_byte(w_byte)) begin
          r_b0  <= w_byte;
          r_idx <= 2'd1;
        end
      end else if (r_idx == IDX_LAST) begin
        // Whole word and toggle change together so the consumer never sees a
        // half-updated packet.
`ifdef PS2_WHEEL_EN
        r_mouse <= {~r_mouse[24], r_b2, r_b1, r_b0};
        r_wheel <= w_byte;
`else
        r_mouse <= {~r_mouse[24], w_byte, r_b1, r_b0};
`endif
        r_idx   <= 2'd0;
      end else begin
        if (r_idx == 2'd1) r_b1 <= w_byte;
`ifdef PS2_WHEEL_EN
        else               r_b2 <= w_byte;
`endif
        r_idx <= r_idx + 2'd1;
      end
    end else if (w_frame_err || w_pkt_to) begin
      r_idx       <= 2'd0;
      r_pkt_timer <= '0;
    end else if (r_idx == 2'd0) begin
      r_pkt_timer <= '0;
    end else if (r_pkt_timer != PT_LAST) begin
      r_pkt_timer <= r_pkt_timer + 1'b1;
    end
  end

  assign ps2_mouse = r_mouse;
  assign frame_err = w_frame_err;
`ifdef PS2_WHEEL_EN
  assign ps2_wheel = r_wheel;
`endif

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// -----------------------------------------------------------------------------
// tb_ps2_mouse_rx
// Directed bench for ps2_mouse_rx (default 3-byte build). Drives PS/2 frames
// bit by bit, counts bit-24 toggles and frame_err pulses, and compares the
// packet word against hand-computed values.
// -----------------------------------------------------------------------------
module tb_ps2_mouse_rx;

  localparam int FILTER_LEN  = 8;
  localparam int BIT_TIMEOUT = 400;
  localparam int PKT_TIMEOUT = 2000;

  // PS/2 bit timing in clk_sys cycles: data set, clock high, clock low, high.
  localparam int T_HI_PRE  = 15;
  localparam int T_LO      = 25;
  localparam int T_HI_POST = 10;

  typedef struct {
    string       name;
    int          n;         // number of bytes sent
    logic [47:0] bytes;     // byte i in bits [8*i +: 8]
    logic [5:0]  bad_par;   // bit i: corrupt parity of byte i
    logic [5:0]  bad_stop;  // bit i: send stop bit 0 for byte i
    logic [23:0] exp_data;
    int          exp_tog;
    int          exp_err;
  } vec_t;

  logic        clk_sys  = 1'b0;
  logic        reset_n  = 1'b0;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic [24:0] ps2_mouse;
  logic        frame_err;
`ifdef PS2_WHEEL_EN
  logic [7:0]  ps2_wheel;
`endif

  int   n_cmp    = 0;
  int   n_fail   = 0;
  int   n_tog    = 0;
  int   n_err    = 0;
  logic last_tog = 1'b0;

  vec_t vecs[9];

  always #5 clk_sys = ~clk_sys;

  ps2_mouse_rx #(
    .FILTER_LEN  (FILTER_LEN),
    .BIT_TIMEOUT (BIT_TIMEOUT),
    .PKT_TIMEOUT (PKT_TIMEOUT)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ps2_mouse (ps2_mouse),
`ifdef PS2_WHEEL_EN
    .ps2_wheel (ps2_wheel),
`endif
    .frame_err (frame_err)
  );

  // Event monitor, sampled away from the active edge.
  initial begin
    forever begin
      @(negedge clk_sys);
      if (ps2_mouse[24] !== last_tog) begin
        n_tog++;
        last_tog = ps2_mouse[24];
      end
      if (frame_err === 1'b1) n_err++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    ps2_data = b;
    cycles(T_HI_PRE);
    if (glitch) begin
      ps2_clk = 1'b0; cycles(1); ps2_clk = 1'b1; cycles(4);
    end
    ps2_clk = 1'b0;
    if (glitch) begin
      cycles(8); ps2_clk = 1'b1; cycles(5); ps2_clk = 1'b0; cycles(T_LO - 13);
    end else begin
      cycles(T_LO);
    end
    ps2_clk = 1'b1;
    cycles(T_HI_POST);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit glitch);
    logic par;
    par = (~^b) ^ bad_par;
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
    send_bit(par, glitch);
    send_bit(~bad_stop, glitch);
    ps2_data = 1'b1;
    cycles(30);
  endtask

  task automatic send_pkt3(input logic [23:0] p, input bit glitch);
    for (int i = 0; i < 3; i++) send_frame(p[8*i +: 8], 1'b0, 1'b0, glitch);
  endtask

  function automatic vec_t mk(input string name, input int n, input logic [47:0] bytes,
                              input logic [5:0] bad_par, input logic [5:0] bad_stop,
                              input logic [23:0] exp_data, input int exp_tog,
                              input int exp_err);
    vec_t v;
    v.name = name; v.n = n; v.bytes = bytes; v.bad_par = bad_par;
    v.bad_stop = bad_stop; v.exp_data = exp_data; v.exp_tog = exp_tog;
    v.exp_err = exp_err;
    return v;
  endfunction

  initial begin
    int   tog0;
    int   err0;
    vec_t v;

    // Bytes listed last-sent first: 48'h..._b2_b1_b0.
    vecs[0] = mk("basic",        3, 48'h0000_00FB_0509, 6'b000000, 6'b000000, 24'hFB0509, 1, 0);
    vecs[1] = mk("bad_parity",   4, 48'h0000_0201_0809, 6'b000001, 6'b000000, 24'h020108, 1, 1);
    vecs[2] = mk("bit3_resync",  4, 48'h0000_2010_0800, 6'b000000, 6'b000000, 24'h201008, 1, 0);
    vecs[3] = mk("ack_skip",     4, 48'h0000_807F_09FA, 6'b000000, 6'b000000, 24'h807F09, 1, 0);
    vecs[4] = mk("bat_skip",     4, 48'h0000_2211_08AA, 6'b000000, 6'b000000, 24'h221108, 1, 0);
    vecs[5] = mk("back_to_back", 6, 48'h0FF0_1802_0108, 6'b000000, 6'b000000, 24'h0FF018, 2, 0);
    vecs[6] = mk("mid_pkt_err",  5, 48'h0003_0209_0108, 6'b000010, 6'b000000, 24'h030209, 1, 1);
    vecs[7] = mk("stop_err",     4, 48'h0000_3B2A_1808, 6'b000000, 6'b000001, 24'h3B2A18, 1, 1);
    vecs[8] = mk("raw_bits",     3, 48'h0000_0080_FFC8, 6'b000000, 6'b000000, 24'h80FFC8, 1, 0);

    cycles(4);
    reset_n = 1'b1;
    cycles(4);
    check("reset ps2_mouse", 32'(ps2_mouse), 32'h0);
    check("reset frame_err", 32'(frame_err), 32'h0);

    for (int k = 0; k < 9; k++) begin
      v    = vecs[k];
      tog0 = n_tog;
      err0 = n_err;
      for (int i = 0; i < v.n; i++)
        send_frame(v.bytes[8*i +: 8], v.bad_par[i], v.bad_stop[i], 1'b0);
      cycles(20);
      check({v.name, " data"},    32'(ps2_mouse[23:0]), 32'(v.exp_data));
      check({v.name, " toggles"}, 32'(n_tog - tog0),    32'(v.exp_tog));
      check({v.name, " errors"},  32'(n_err - err0),    32'(v.exp_err));
    end

    // Packet timeout: the stale 08,01 must be dropped before 08,03,04.
    tog0 = n_tog;
    send_frame(8'h08, 1'b0, 1'b0, 1'b0);
    send_frame(8'h01, 1'b0, 1'b0, 1'b0);
    cycles(PKT_TIMEOUT + 100);
    send_pkt3(24'h040308, 1'b0);
    cycles(20);
    check("pkt_timeout data",    32'(ps2_mouse[23:0]), 32'h040308);
    check("pkt_timeout toggles", 32'(n_tog - tog0),    32'd1);

    // Bit timeout: a truncated frame is discarded silently.
    tog0 = n_tog;
    err0 = n_err;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    cycles(BIT_TIMEOUT + 100);
    send_pkt3(24'h020109, 1'b0);
    cycles(20);
    check("bit_timeout data",    32'(ps2_mouse[23:0]), 32'h020109);
    check("bit_timeout toggles", 32'(n_tog - tog0),    32'd1);
    check("bit_timeout errors",  32'(n_err - err0),    32'd0);

    // Short clock glitches in both phases of every bit.
    tog0 = n_tog;
    err0 = n_err;
    send_pkt3(24'hAA550A, 1'b1);
    cycles(20);
    check("glitch data",    32'(ps2_mouse[23:0]), 32'hAA550A);
    check("glitch toggles", 32'(n_tog - tog0),    32'd1);
    check("glitch errors",  32'(n_err - err0),    32'd0);

    // Reset mid-frame, then a clean packet.
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    reset_n = 1'b0;
    cycles(3);
    check("midreset ps2_mouse", 32'(ps2_mouse), 32'h0);
    check("midreset frame_err", 32'(frame_err), 32'h0);
    ps2_data = 1'b1;
    ps2_clk  = 1'b1;
    reset_n  = 1'b1;
    cycles(50);
    tog0 = n_tog;
    send_pkt3(24'h0D0C08, 1'b0);
    cycles(20);
    check("post_reset data",    32'(ps2_mouse[23:0]), 32'h0D0C08);
    check("post_reset bit24",   32'(ps2_mouse[24]),   32'd1);
    check("post_reset toggles", 32'(n_tog - tog0),    32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
